// File: rtl/wshb_frame_reader_pkg.sv
// Shared types and constants for the Wishbone framebuffer reader.
// Pixel/FIFO entry types, FSM states and CTI encodings.
package wshb_frame_reader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST
    } state_t;

    typedef logic [15:0] pixel_t;

    typedef struct packed {
        logic   sof;
        pixel_t data;
    } fifo_entry_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    function automatic int unsigned npix(
        input int unsigned h,
        input int unsigned v
    );
        return h * v;
    endfunction

endpackage

// File: rtl/wshb_frame_reader_if.sv
// Wishbone 16-bit master/slave bundle for the framebuffer reader.
// WSHB_FRAME_READER_CTI_EN adds registered-feedback cti/bte signals.
interface wshb_frame_reader_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] wb_adr_o;
    logic [15:0]       wb_dat_i;
    logic              wb_cyc_o;
    logic              wb_stb_o;
    logic              wb_we_o;
    logic [1:0]        wb_sel_o;
    logic              wb_ack_i;
`ifdef WSHB_FRAME_READER_CTI_EN
    logic [2:0]        wb_cti_o;
    logic [1:0]        wb_bte_o;

    modport master (
        output wb_adr_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o,
        output wb_cti_o, wb_bte_o,
        input  wb_dat_i, wb_ack_i
    );
    modport slave (
        input  wb_adr_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o,
        input  wb_cti_o, wb_bte_o,
        output wb_dat_i, wb_ack_i
    );
`else
    modport master (
        output wb_adr_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o,
        input  wb_dat_i, wb_ack_i
    );
    modport slave (
        input  wb_adr_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o,
        output wb_dat_i, wb_ack_i
    );
`endif
endinterface

// File: rtl/wshb_frame_reader_pix_fifo.sv
// Single-clock show-ahead FIFO of tagged pixels.
// Head entry is read straight from the register array.
module pix_fifo
    import wshb_frame_reader_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  fifo_entry_t              wr_data,
    input  logic                     pop,
    output fifo_entry_t              rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    fifo_entry_t mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a write when the head leaves this cycle.
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/wshb_frame_reader.sv
// Wishbone burst reader streaming a framebuffer into a pixel stream.
// Define WSHB_FRAME_READER_CTI_EN to drive cti/bte burst tags.
module wshb_frame_reader
    import wshb_frame_reader_pkg::*;
#(
    parameter int HDISP      = 640,
    parameter int VDISP      = 480,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 64,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [ADDR_W-1:0] frame_base,
    wshb_frame_reader_if.master wb,
    output pixel_t            pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_sof,
    output logic              underflow
);
    localparam int unsigned NPIX = npix(HDISP, VDISP);
    localparam int CW = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int FW = $clog2(FIFO_DEPTH) + 1;

    state_t            state;
    state_t            state_nxt;
    logic [CW-1:0]     pix_cnt;
    logic [ADDR_W-1:0] adr;
    logic [BW-1:0]     beat;
    logic              beat_ack;
    logic              last_beat;
    logic              last_pix;
    logic              room;
    logic [FW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    fifo_entry_t       wr_entry;
    fifo_entry_t       head;

    assign beat_ack  = (state == BURST) && wb.wb_ack_i;
    assign last_beat = (beat == BW'(BURST_LEN - 1));
    assign last_pix  = (pix_cnt == CW'(NPIX - 1));
    assign room      = !fifo_full &&
                       ((FW'(FIFO_DEPTH) - fifo_count) >= FW'(BURST_LEN));

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (enable) state_nxt = WAIT;
            WAIT: begin
                if (!enable)   state_nxt = IDLE;
                else if (room) state_nxt = BURST;
            end
            BURST:   if (beat_ack && last_beat) state_nxt = WAIT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            pix_cnt   <= '0;
            adr       <= '0;
            beat      <= '0;
            underflow <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && enable) begin
                adr     <= frame_base;
                pix_cnt <= '0;
            end
            if (beat_ack) begin
                beat <= last_beat ? '0 : beat + 1'b1;
                // Wrap may land mid-burst; the burst keeps going from the base.
                if (last_pix) begin
                    pix_cnt <= '0;
                    adr     <= frame_base;
                end else begin
                    pix_cnt <= pix_cnt + 1'b1;
                    adr     <= adr + ADDR_W'(2);
                end
            end
            if (state != IDLE && pix_ready && fifo_empty) begin
                underflow <= 1'b1;
            end
        end
    end

    assign wb.wb_adr_o = adr;
    assign wb.wb_cyc_o = (state == BURST);
    assign wb.wb_stb_o = (state == BURST);
    assign wb.wb_we_o  = 1'b0;
    assign wb.wb_sel_o = 2'b11;
`ifdef WSHB_FRAME_READER_CTI_EN
    assign wb.wb_cti_o = (state != BURST) ? CTI_CLASSIC :
                         last_beat        ? CTI_EOB : CTI_INCR;
    assign wb.wb_bte_o = 2'b00;
`endif

    assign wr_entry.sof  = (pix_cnt == '0);
    assign wr_entry.data = wb.wb_dat_i;

    pix_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (beat_ack),
        .wr_data (wr_entry),
        .pop     (pix_valid && pix_ready),
        .rd_data (head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign pix_valid = !fifo_empty;
    assign pix_data  = head.data;
    assign pix_sof   = head.sof && !fifo_empty;

endmodule
